// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write arbiter.
//   NREGS_DEFAULT / W_DEFAULT : default register count and data width
//   state_e                   : arbiter sequencing states
//   prio_e                    : which requester wins the next contention
package regfile_pkg;

    localparam int NREGS_DEFAULT = 8;
    localparam int W_DEFAULT     = 8;

    typedef enum logic {
        ARB,
        CLEAR
    } state_e;

    typedef enum logic {
        PRIO_A,
        PRIO_B
    } prio_e;

endpackage : regfile_pkg

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: bundle of requester handshakes, clear control
// and the register-file write port.
//   reqA/addrA/dataA/gntA : requester A write request, target, data, grant
//   reqB/addrB/dataB/gntB : requester B, same meaning
//   clr_start / clr_busy  : clear-sequence trigger and in-progress flag
//   we / waddr / wdata    : registered one-hot write enable, address, data
// Modports: master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int W     = W_DEFAULT
) ();

    localparam int AW = $clog2(NREGS);

    logic          reqA;
    logic [AW-1:0] addrA;
    logic [W-1:0]  dataA;
    logic          gntA;

    logic          reqB;
    logic [AW-1:0] addrB;
    logic [W-1:0]  dataB;
    logic          gntB;

    logic          clr_start;
    logic          clr_busy;

    logic [NREGS-1:0] we;
    logic [AW-1:0]    waddr;
    logic [W-1:0]     wdata;

    modport master (
        output reqA, addrA, dataA,
        output reqB, addrB, dataB,
        output clr_start,
        input  gntA, gntB, clr_busy,
        input  we, waddr, wdata
    );

    modport slave (
        input  reqA, addrA, dataA,
        input  reqB, addrB, dataB,
        input  clr_start,
        output gntA, gntB, clr_busy,
        output we, waddr, wdata
    );

endinterface : regfile_write_arbiter_if

// File: rtl/regfile_write_arbiter_write_decoder.sv
// write_decoder: AW-to-NREGS one-hot decoder for the register-file write
// enable. Shared by arbitrated writes and clear-sequence writes.
//   en     : in  1     drive a write this cycle
//   addr   : in  AW    target register
//   onehot : out NREGS one-hot enable (all zero when en = 0)
module write_decoder #(
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : write_decoder

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter and clear sequencer for the
// shared register-file write port.
//   Clk : in  clock, rising edge
//   CLR : in  asynchronous active-low reset
//   bus : slave modport carrying both requesters, clear control and the
//         registered write port (we / waddr / wdata)
// In ARB, one requester wins per cycle (prio breaks ties, then flips to the
// loser). A sampled clr_start moves to CLEAR, which writes zero to every
// register in ascending order, one per cycle, then returns to ARB.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int W     = W_DEFAULT,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                    Clk,
    input  logic                    CLR,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [AW:0] CNT_DONE = (AW+1)'(NREGS);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_e           state_q, state_d;
    prio_e            prio_q, prio_d;
    // One extra bit so reaching NREGS is distinguishable from index 0.
    logic [AW:0]      cnt_q, cnt_d;
    logic [NREGS-1:0] we_q, we_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [W-1:0]     wdata_q, wdata_d;

    logic             gnt_a, gnt_b;
    logic             dec_en;
    logic [AW-1:0]    dec_addr;

    write_decoder #(.NREGS(NREGS)) u_write_decoder (
        .en     (dec_en),
        .addr   (dec_addr),
        .onehot (we_d)
    );

    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        dec_en   = 1'b0;
        dec_addr = '0;

        case (state_q)
            ARB: begin
                if (bus.clr_start) begin
                    // The first clear write (register 0) issues on the
                    // accepting edge itself, so the counter starts at 1.
                    state_d  = CLEAR;
                    cnt_d    = CNT_ONE;
                    dec_en   = 1'b1;
                    dec_addr = '0;
                    waddr_d  = '0;
                    wdata_d  = '0;
                end else begin
                    gnt_a = bus.reqA && (!bus.reqB || prio_q == PRIO_A);
                    gnt_b = bus.reqB && !gnt_a;
                    if (gnt_a) begin
                        dec_en   = 1'b1;
                        dec_addr = bus.addrA;
                        waddr_d  = bus.addrA;
                        wdata_d  = bus.dataA;
                        prio_d   = PRIO_B;
                    end else if (gnt_b) begin
                        dec_en   = 1'b1;
                        dec_addr = bus.addrB;
                        waddr_d  = bus.addrB;
                        wdata_d  = bus.dataB;
                        prio_d   = PRIO_A;
                    end
                end
            end

            CLEAR: begin
                // clr_start is deliberately not looked at here.
                if (cnt_q == CNT_DONE) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    dec_en   = 1'b1;
                    dec_addr = cnt_q[AW-1:0];
                    waddr_d  = cnt_q[AW-1:0];
                    wdata_d  = '0;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge Clk or negedge CLR) begin
        if (!CLR) begin
            state_q <= ARB;
            prio_q  <= PRIO_A;
            cnt_q   <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Grants are suppressed while reset is held so no requester believes a
    // write was accepted that the reset will discard.
    assign bus.gntA     = gnt_a && CLR;
    assign bus.gntB     = gnt_b && CLR;
    assign bus.clr_busy = (state_q == CLEAR);
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;

endmodule : regfile_write_arbiter

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the shared write port of the register file. Two requesters (A, B) compete for one write port. The block grants them round-robin, drives the one-hot write enable, address and data into the register file, and runs a built-in clear sequence that zeroes every register on request. It sits between the datapath requesters and the register file's write decoder/`regn` array.

## Interface
Parameters:
- `NREGS`, 8: number of registers in the file (power of two, ≥2).
- `W`, 8: register data width.
- `AW`, `$clog2(NREGS)`: address width (derived, not overridden).

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `CLR`  in  1  asynchronous, active-low reset.
- `reqA`  in  1  requester A write request.
- `addrA`  in  AW  requester A target register.
- `dataA`  in  W  requester A write data.
- `gntA`  out  1  A's write accepted this cycle (combinational).
- `reqB`, `addrB`, `dataB`, `gntB`: same as the A ports, for requester B.
- `clr_start`  in  1  pulse that starts the clear sequence.
- `clr_busy`  out  1  clear sequence in progress.
- `we`  out  NREGS  one-hot register-file write enable (registered).
- `waddr`  out  AW  write address (registered).
- `wdata`  out  W  write data (registered).

## Operation
- States: `ARB` (reset state) and `CLEAR`.
- In `ARB`, a transfer happens at an edge where `reqX && gntX`.
  - Only one requester: it is granted.
  - Both requesting: the priority pointer `prio` decides.
  - `prio` resets to A. After any grant it points to the requester that was not granted, so continuous contention alternates A, B, A, B, …
- Grant gating: `gntA` and `gntB` are both 0 when `clr_start` = 1, while the clear is running (`clr_busy` = 1), and in the edge-transition cycle at the end of the clear. `clr_start` wins over any request in the same cycle.
- On a transfer, at the next edge: `we` = onehot(addr), `waddr` = addr, `wdata` = data, all held for exactly one cycle. With no transfer, `we` = 0 and `waddr`/`wdata` hold their previous values.
- Clear sequence:
  - Triggered when `clr_start` is sampled high in `ARB`.
  - Issues NREGS writes in order: `we` = onehot(i), `waddr` = i, `wdata` = 0, for i = 0..NREGS-1 on consecutive cycles.
  - Then returns to `ARB`. `prio` is unchanged by the clear.
- `clr_start` sampled while in `CLEAR` is ignored; it is neither queued nor restarts the sequence.
- Requests are never queued. A requester holds `req`/`addr`/`data` stable until it sees `gnt`.
- Reset (`CLR` = 0, asynchronous) at any time, including mid-clear: state = `ARB`, `prio` = A, clear counter = 0, `we` = 0, `waddr` = 0, `wdata` = 0, `clr_busy` = 0. A partially completed clear is abandoned, not resumed.

## Timing
- Grant latency: 0 cycles (`gnt` is combinational from `req`, state and `prio`).
- Write latency: 1 cycle from the accepting edge to `we` being asserted.
- Throughput: one write per cycle.
- Clear timing, with `clr_start` sampled at edge E0:
  - `we` = onehot(i) and `clr_busy` = 1 in the cycle following edge E_i, for i = 0..NREGS-1.
  - `clr_busy` is high for exactly NREGS cycles.
  - The earliest grant is in the cycle after the last clear write. The total grant blackout is NREGS+1 cycles, counting the `clr_start` cycle.
- `we` is never more than one-hot. `we` = 0 in every cycle with no transfer and no clear write.

## Structure
- Shared package `regfile_pkg`: defaults for `NREGS` and `W`, and the state enum `{ARB, CLEAR}`.
- One natural sub-module: `write_decoder`, an AW-to-NREGS one-hot decoder. It is used for both arbitrated and clear writes, feeding the `we` register.
- The top level holds the FSM, `prio`, the clear counter (AW+1 bits, so the terminal count can be detected) and the output registers.

## Test plan
All scenarios use NREGS = 8, W = 8.
- **Reset:** hold `CLR` = 0 with random inputs → `we` = 0, `waddr` = 0, `wdata` = 0, `clr_busy` = 0, `gntA` = `gntB` = 0.
- **Single requester:** `reqA` = 1, `addrA` = 3, `dataA` = 8'h5A for one cycle → `gntA` = 1 that cycle; next cycle `we` = 8'b0000_1000, `waddr` = 3, `wdata` = 8'h5A; following cycle `we` = 0.
- **Contention:** `reqA` = `reqB` = 1 held for 4 cycles after reset, with `addrA` = 1/`dataA` = 8'h11 and `addrB` = 2/`dataB` = 8'h22 → grants A, B, A, B; `wdata` sequence 11, 22, 11, 22, each one cycle after its grant.
- **Clear with pending request:** `clr_start` pulse with `reqA` = 1 held → `gntA` = 0 for 9 cycles; `we` walks 01, 02, …, 80 with `wdata` = 0 and `clr_busy` = 1 for 8 cycles; `gntA` = 1 in the next cycle.
- **`clr_start` during clear:** second `clr_start` pulse during clear write 4 → sequence still ends after `we` = 8'h80; no restart.
- **Reset mid-clear:** assert `CLR` = 0 after clear write 2 → `we` and `clr_busy` drop to 0 immediately. After release, `reqA` and `reqB` together → A granted first.
